nx_mimosa_track_tx: RTL and testbench

- Track-report transmitter at the output end of the IMM tracker.
- Accepts one completed track update per handshake: state vector, mode probabilities, NIS and adaptive-Q scale, all in Q15.16.
- Serialises the update into a framed 32-bit AXI-Stream for the host-side report receiver: header, payload, XOR checksum.
- Clamps probability and Q-scale fields to their legal ranges before transmission.

---
 rtl/nx_mimosa_pkg_v2.sv | 37 +++
 rtl/nx_mimosa_trk_capture.sv | 51 +++++
 rtl/nx_mimosa_track_tx.sv | 145 ++++++++++++++
 tb/tb_nx_mimosa_track_tx.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nx_mimosa_pkg_v2.sv
// Shared types and constants for the IMM tracker datapath and report path.
// Q15.16 fixed-point helpers, track-report framing constants, tx FSM states.
package nx_mimosa_pkg_v2;

    typedef logic signed [31:0] fp_t;

    localparam fp_t FP_ZERO     = 32'sh0000_0000;
    localparam fp_t FP_ONE      = 32'sh0001_0000;
    localparam fp_t Q_MIN_SCALE = 32'sh0000_199A;
    localparam fp_t Q_MAX_SCALE = 32'sh0005_0000;

    localparam logic [7:0] TRK_SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        PAY,
        CSUM
    } tx_state_t;

    // Header + state + mode probabilities + nis + qscale + checksum.
    function automatic int trk_n_words(input int sd, input int nm);
        return 1 + sd + nm + 3;
    endfunction

    function automatic fp_t fp_clamp(input fp_t x, input fp_t lo, input fp_t hi);
        fp_t r;
        r = x;
        if (x < lo) begin
            r = lo;
        end else if (x > hi) begin
            r = hi;
        end
        return r;
    endfunction

endpackage

// File: rtl/nx_mimosa_trk_capture.sv
// Track-update capture: registers and clamps one update, exposes payload words.
// Ports: clk, rst, load, trk_* bundle in; idx select in; id and word out.
module nx_mimosa_trk_capture
    import nx_mimosa_pkg_v2::*;
#(
    parameter int STATE_DIM = 4,
    parameter int N_MODELS  = 3,
    parameter int ID_W      = 3,
    parameter int IDX_W     = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [ID_W-1:0]           trk_id,
    input  logic [STATE_DIM*32-1:0]   trk_state,
    input  logic [N_MODELS*32-1:0]    trk_mu,
    input  logic [31:0]               trk_nis,
    input  logic [31:0]               trk_qscale,
    input  logic [IDX_W-1:0]          idx,
    output logic [ID_W-1:0]           id,
    output logic [31:0]               word
);

    localparam int NP = STATE_DIM + N_MODELS + 2;

    logic [31:0] pay [NP];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NP; i++) begin
                pay[i] <= '0;
            end
            id <= '0;
        end else if (load) begin
            for (int k = 0; k < STATE_DIM; k++) begin
                pay[k] <= trk_state[32*k +: 32];
            end
            for (int k = 0; k < N_MODELS; k++) begin
                pay[STATE_DIM+k] <= fp_clamp(fp_t'(trk_mu[32*k +: 32]),
                                             FP_ZERO, FP_ONE);
            end
            pay[STATE_DIM+N_MODELS]   <= trk_nis;
            pay[STATE_DIM+N_MODELS+1] <= fp_clamp(fp_t'(trk_qscale),
                                                  Q_MIN_SCALE, Q_MAX_SCALE);
            id <= trk_id;
        end
    end

    assign word = (idx < IDX_W'(NP)) ? pay[idx] : '0;

endmodule

// File: rtl/nx_mimosa_track_tx.sv
// Track-report transmitter: frames a captured update onto 32-bit AXI-Stream.
// Ports: trk_* capture handshake in, m_t* stream out, frm_cnt frame counter.
module nx_mimosa_track_tx
    import nx_mimosa_pkg_v2::*;
#(
    parameter int         STATE_DIM = 4,
    parameter int         N_MODELS  = 3,
    parameter int         ID_W      = 3,
    parameter logic [7:0] SYNC_BYTE = TRK_SYNC_BYTE
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      trk_valid,
    output logic                      trk_ready,
    input  logic [ID_W-1:0]           trk_id,
    input  logic [STATE_DIM*32-1:0]   trk_state,
    input  logic [N_MODELS*32-1:0]    trk_mu,
    input  logic [31:0]               trk_nis,
    input  logic [31:0]               trk_qscale,
    output logic [31:0]               m_tdata,
    output logic                      m_tvalid,
    input  logic                      m_tready,
    output logic                      m_tlast,
    output logic                      m_tuser,
    output logic [15:0]               frm_cnt
);

    localparam int N_WORDS = trk_n_words(STATE_DIM, N_MODELS);
    localparam int NP      = N_WORDS - 2;
    localparam int IDX_W   = $clog2(NP);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NP - 1);

    tx_state_t        st;
    tx_state_t        nxt;
    logic [IDX_W-1:0] idx;
    logic [7:0]       seq;
    logic [31:0]      csum;
    logic [ID_W-1:0]  cap_id;
    logic [31:0]      pay_word;
    logic [31:0]      header;
    logic             load;
    logic             acc;

    nx_mimosa_trk_capture #(
        .STATE_DIM (STATE_DIM),
        .N_MODELS  (N_MODELS),
        .ID_W      (ID_W),
        .IDX_W     (IDX_W)
    ) u_cap (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .trk_id     (trk_id),
        .trk_state  (trk_state),
        .trk_mu     (trk_mu),
        .trk_nis    (trk_nis),
        .trk_qscale (trk_qscale),
        .idx        (idx),
        .id         (cap_id),
        .word       (pay_word)
    );

    assign header = {SYNC_BYTE, seq, 8'(cap_id), 8'(N_WORDS)};

    // Outputs decode only registered state, so nothing in the stream or
    // capture handshake depends combinationally on m_tready or trk_valid.
    always_comb begin
        nxt       = st;
        trk_ready = 1'b0;
        m_tvalid  = 1'b0;
        m_tuser   = 1'b0;
        m_tlast   = 1'b0;
        m_tdata   = '0;
        load      = 1'b0;
        acc       = 1'b0;
        unique case (st)
            IDLE: begin
                trk_ready = 1'b1;
                if (trk_valid) begin
                    load = 1'b1;
                    nxt  = HDR;
                end
            end
            HDR: begin
                m_tvalid = 1'b1;
                m_tuser  = 1'b1;
                m_tdata  = header;
                acc      = m_tready;
                if (m_tready) begin
                    nxt = PAY;
                end
            end
            PAY: begin
                m_tvalid = 1'b1;
                m_tdata  = pay_word;
                acc      = m_tready;
                if (m_tready && idx == LAST) begin
                    nxt = CSUM;
                end
            end
            CSUM: begin
                m_tvalid = 1'b1;
                m_tlast  = 1'b1;
                m_tdata  = csum;
                if (m_tready) begin
                    nxt = IDLE;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st <= IDLE;
        end else begin
            st <= nxt;
        end
    end

    // The checksum folds in each word as it is accepted, so a stall only
    // holds it; the header seeds it and the CSUM word presents it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx     <= '0;
            seq     <= '0;
            csum    <= '0;
            frm_cnt <= '0;
        end else begin
            if (st == HDR && m_tready) begin
                idx <= '0;
            end else if (st == PAY && m_tready) begin
                idx <= idx + 1'b1;
            end
            if (acc) begin
                csum <= (st == HDR) ? header : (csum ^ pay_word);
            end
            if (st == CSUM && m_tready) begin
                seq     <= seq + 8'd1;
                frm_cnt <= frm_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_nx_mimosa_track_tx.sv
// Self-checking bench for nx_mimosa_track_tx (4 states, 3 models, 3-bit id).
// Frames are predicted from the update fields with a plain reference model.
module tb_nx_mimosa_track_tx;

    localparam int SD = 4;
    localparam int NM = 3;
    localparam int NW = 1 + SD + NM + 3;

    typedef struct {
        logic [2:0]  id;
        logic [31:0] st [SD];
        logic [31:0] mu [NM];
        logic [31:0] nis;
        logic [31:0] qs;
    } upd_t;

    typedef struct {
        logic [31:0] mu0;
        logic [31:0] mu1;
        logic [31:0] qs;
        logic [31:0] x_mu0;
        logic [31:0] x_mu1;
        logic [31:0] x_qs;
    } clamp_vec_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           trk_valid;
    logic           trk_ready;
    logic [2:0]     trk_id;
    logic [SD*32-1:0] trk_state;
    logic [NM*32-1:0] trk_mu;
    logic [31:0]    trk_nis;
    logic [31:0]    trk_qscale;
    logic [31:0]    m_tdata;
    logic           m_tvalid;
    logic           m_tready;
    logic           m_tlast;
    logic           m_tuser;
    logic [15:0]    frm_cnt;

    nx_mimosa_track_tx #(
        .STATE_DIM (SD),
        .N_MODELS  (NM),
        .ID_W      (3),
        .SYNC_BYTE (8'hA5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .trk_valid  (trk_valid),
        .trk_ready  (trk_ready),
        .trk_id     (trk_id),
        .trk_state  (trk_state),
        .trk_mu     (trk_mu),
        .trk_nis    (trk_nis),
        .trk_qscale (trk_qscale),
        .m_tdata    (m_tdata),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tlast    (m_tlast),
        .m_tuser    (m_tuser),
        .frm_cnt    (frm_cnt)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;
    int seq_m = 0;
    int frm_m = 0;
    logic [31:0] exp_w [NW];
    logic [31:0] got [NW];
    logic [31:0] ref_got [NW];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        vecs++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    function automatic logic [31:0] clampv(input logic [31:0] x,
                                           input int lo, input int hi);
        int v;
        v = $signed(x);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return x;
    endfunction

    // Reference frame: header, raw state, clamped mu, nis, clamped qscale,
    // then XOR of everything before it.
    task automatic build(input upd_t u);
        logic [31:0] x;
        exp_w[0] = {8'hA5, 8'(seq_m), 5'd0, u.id, 8'(NW)};
        for (int k = 0; k < SD; k++) exp_w[1+k] = u.st[k];
        for (int k = 0; k < NM; k++) exp_w[1+SD+k] = clampv(u.mu[k], 0, 65536);
        exp_w[1+SD+NM] = u.nis;
        exp_w[2+SD+NM] = clampv(u.qs, 6554, 327680);
        x = '0;
        for (int k = 0; k < NW - 1; k++) x ^= exp_w[k];
        exp_w[NW-1] = x;
    endtask

    task automatic drive(input upd_t u);
        trk_id = u.id;
        for (int k = 0; k < SD; k++) trk_state[32*k +: 32] = u.st[k];
        for (int k = 0; k < NM; k++) trk_mu[32*k +: 32] = u.mu[k];
        trk_nis = u.nis;
        trk_qscale = u.qs;
    endtask

    function automatic upd_t rnd();
        upd_t u;
        u.id = 3'($urandom_range(0, 7));
        for (int k = 0; k < SD; k++) u.st[k] = $urandom;
        for (int k = 0; k < NM; k++)
            u.mu[k] = ($urandom_range(0, 3) == 0) ? $urandom
                                                  : $urandom_range(0, 65600);
        u.nis = $urandom;
        u.qs = ($urandom_range(0, 3) == 0) ? $urandom
                                           : $urandom_range(0, 393216);
        return u;
    endfunction

    // Called on a falling edge. Offers u, waits for the capture, then
    // receives the frame with m_tready high pct% of cycles. Every cycle the
    // visible word is compared with the model, which also covers stability
    // across stalls. Returns on the falling edge before the final accept.
    task automatic xfer(input upd_t u, input int pct, input bit nv,
                        input upd_t nu, output int waits);
        int k;
        int cyc;
        drive(u);
        trk_valid = 1'b1;
        waits = 0;
        while (!trk_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        if (!trk_ready) begin
            chk("capture_wait", 32'(trk_ready), 32'd1);
            trk_valid = 1'b0;
            return;
        end
        build(u);
        k = 0;
        cyc = 0;
        @(negedge clk);
        if (nv) begin
            drive(nu);
        end else begin
            trk_valid = 1'b0;
            drive(rnd());
        end
        while (k < NW && cyc < 500) begin
            m_tready = ($urandom_range(0, 99) < pct);
            chk("trk_ready_busy", 32'(trk_ready), 32'd0);
            chk("tvalid", 32'(m_tvalid), 32'd1);
            chk($sformatf("tdata[%0d]", k), m_tdata, exp_w[k]);
            chk($sformatf("tuser[%0d]", k), 32'(m_tuser), 32'(k == 0));
            chk($sformatf("tlast[%0d]", k), 32'(m_tlast), 32'(k == NW - 1));
            if (m_tvalid && m_tready) begin
                got[k] = m_tdata;
                k++;
            end
            if (k < NW) @(negedge clk);
            cyc++;
        end
        if (k < NW) chk("frame_timeout", k, NW);
        seq_m = (seq_m + 1) % 256;
        frm_m = (frm_m + 1) % 65536;
    endtask

    upd_t u0;
    upd_t u1;
    upd_t dummy;
    clamp_vec_t cv [3];
    int w;

    initial begin
        rst = 1'b1;
        trk_valid = 1'b0;
        m_tready = 1'b0;
        dummy = rnd();
        drive(dummy);
        #1;
        chk("rst_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_tdata", m_tdata, 32'd0);
        chk("rst_frm_cnt", 32'(frm_cnt), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_trk_ready", 32'(trk_ready), 32'd1);
        chk("rst_tlast", 32'(m_tlast), 32'd0);
        chk("rst_tuser", 32'(m_tuser), 32'd0);

        // Single reference frame
        u0.id = 3'd5;
        u0.st[0] = 32'h0001_0000;
        u0.st[1] = 32'h0002_0000;
        u0.st[2] = 32'hFFFF_8000;
        u0.st[3] = 32'h0000_4000;
        u0.mu[0] = 32'h0000_E666;
        u0.mu[1] = 32'h0000_0CCD;
        u0.mu[2] = 32'h0000_0CCD;
        u0.nis = 32'h0003_0000;
        u0.qs = 32'h0001_8000;
        xfer(u0, 100, 1'b0, dummy, w);
        chk("hdr_single", got[0], 32'hA500_050B);
        chk("csum_single", got[10],
            got[0] ^ got[1] ^ got[2] ^ got[3] ^ got[4] ^ got[5] ^
            got[6] ^ got[7] ^ got[8] ^ got[9]);
        for (int k = 0; k < NW; k++) ref_got[k] = got[k];
        @(negedge clk);
        chk("frm_cnt_single", 32'(frm_cnt), 32'd1);

        // Clamp table
        cv[0] = '{32'h0001_8000, 32'hFFFF_0000, 32'h000A_0000,
                  32'h0001_0000, 32'h0000_0000, 32'h0005_0000};
        cv[1] = '{32'h0001_8000, 32'hFFFF_0000, 32'h0000_0100,
                  32'h0001_0000, 32'h0000_0000, 32'h0000_199A};
        cv[2] = '{32'h0000_8000, 32'h0001_0000, 32'h0000_199A,
                  32'h0000_8000, 32'h0001_0000, 32'h0000_199A};
        for (int i = 0; i < 3; i++) begin
            u1 = rnd();
            u1.mu[0] = cv[i].mu0;
            u1.mu[1] = cv[i].mu1;
            u1.qs = cv[i].qs;
            xfer(u1, 100, 1'b0, dummy, w);
            chk($sformatf("clamp%0d_mu0", i), got[5], cv[i].x_mu0);
            chk($sformatf("clamp%0d_mu1", i), got[6], cv[i].x_mu1);
            chk($sformatf("clamp%0d_qs", i), got[9], cv[i].x_qs);
        end

        // Back-pressure: same payload as the free-flowing run
        for (int r = 0; r < 4; r++) begin
            xfer(u0, 30, 1'b0, dummy, w);
            for (int k = 1; k < NW - 1; k++)
                chk($sformatf("bp_payload[%0d]", k), got[k], ref_got[k]);
        end
        for (int r = 0; r < 6; r++) xfer(rnd(), 30, 1'b0, dummy, w);
        @(negedge clk);
        chk("frm_cnt_bp", 32'(frm_cnt), 32'(frm_m));

        // Overlap: next update held valid through the frame
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seq_m = 0;
        frm_m = 0;
        @(negedge clk);
        u1 = rnd();
        xfer(rnd(), 100, 1'b1, u1, w);
        xfer(u1, 100, 1'b0, dummy, w);
        chk("overlap_wait", w, 1);
        chk("overlap_seq", 32'(got[0][23:16]), 32'd1);

        // Reset during word 4
        @(negedge clk);
        u1 = rnd();
        drive(u1);
        trk_valid = 1'b1;
        m_tready = 1'b1;
        @(negedge clk);
        trk_valid = 1'b0;
        build(u1);
        for (int k = 0; k < 4; k++) @(negedge clk);
        chk("pre_rst_word4", m_tdata, exp_w[4]);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_tvalid", 32'(m_tvalid), 32'd0);
        chk("mid_rst_tlast", 32'(m_tlast), 32'd0);
        chk("mid_rst_tdata", m_tdata, 32'd0);
        chk("mid_rst_frm_cnt", 32'(frm_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seq_m = 0;
        frm_m = 0;
        @(negedge clk);
        chk("post_rst_ready", 32'(trk_ready), 32'd1);

        // Wrap: 257 frames back to back, seq rolls 255 -> 0
        for (int f = 0; f < 257; f++) begin
            xfer(rnd(), 100, 1'b0, dummy, w);
            if (f == 255) begin
                @(negedge clk);
                chk("frm_cnt_256", 32'(frm_cnt), 32'd256);
                chk("seq_255", 32'(got[0][23:16]), 32'd255);
            end
        end
        chk("seq_wrap", 32'(got[0][23:16]), 32'd0);
        @(negedge clk);
        chk("frm_cnt_final", 32'(frm_cnt), 32'd257);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
